// File: rtl/nmi_i2s_tx.sv
// Memory-mapped I2S transmitter: a stereo-word FIFO fed over a valid/ready bus,
// drained by a divider-clocked frame engine that shifts Philips I2S MSB-first.
module nmi_i2s_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        i2s_sck_o,
    output logic        i2s_ws_o,
    output logic        i2s_sd_o,
    output logic        irq_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic             ready_q;
    logic [31:0]      rdata_q;
    logic             en_q, en_d;
    logic [7:0]       clkdiv_q, clkdiv_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic             irq_en_q, irq_en_d;
    logic             ovf_q, ovf_d;
    logic             udr_q, udr_d;
    logic             irq_q;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0]       div_cnt_q, div_lim_q;
    logic             sck_q, ws_q, sd_q;
    logic [31:0]      sr_q;
    logic [4:0]       bit_q;

    logic             accept, is_read, is_write;
    logic [1:0]       sel;
    logic             full, empty, push_req, push;
    logic             terminal, fall_ev, load, pop;
    logic [31:0]      rd_val;
    logic             unused_addr;

    assign unused_addr = &{1'b0, mem_addr_i[31:4], mem_addr_i[1:0]};

    assign accept   = mem_valid_i & ~ready_q;
    assign is_write = accept & (mem_wstrb_i != 4'h0);
    assign is_read  = accept & (mem_wstrb_i == 4'h0);
    assign sel      = mem_addr_i[3:2];
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = is_write && (sel == 2'd2) && (mem_wstrb_i == 4'hF);
    assign push     = push_req & ~full;

    // Falling SCK events drive the frame; pop decisions use pre-push occupancy.
    assign terminal = en_q & (div_cnt_q == div_lim_q);
    assign fall_ev  = terminal & sck_q;
    assign load     = fall_ev & (bit_q == 5'd31);
    assign pop      = load & ~empty;

    always_comb begin
        rd_val = '0;
        case (sel)
            2'd0: begin
                rd_val[0]    = en_q;
                rd_val[15:8] = clkdiv_q;
            end
            2'd1: begin
                rd_val[0]          = full;
                rd_val[1]          = empty;
                rd_val[2]          = ovf_q;
                rd_val[3]          = udr_q;
                rd_val[8 +: CNT_W] = count_q;
            end
            2'd3: begin
                rd_val[CNT_W-1:0] = thresh_q;
                rd_val[16]        = irq_en_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        clkdiv_d = clkdiv_q;
        thresh_d = thresh_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        udr_d    = udr_q;
        if (is_write) begin
            case (sel)
                2'd0: begin
                    if (mem_wstrb_i[0]) en_d     = mem_wdata_i[0];
                    if (mem_wstrb_i[1]) clkdiv_d = mem_wdata_i[15:8];
                end
                2'd1: begin
                    if (mem_wstrb_i[0] && mem_wdata_i[2]) ovf_d = 1'b0;
                    if (mem_wstrb_i[0] && mem_wdata_i[3]) udr_d = 1'b0;
                end
                2'd3: begin
                    if (mem_wstrb_i[0]) thresh_d = mem_wdata_i[CNT_W-1:0];
                    if (mem_wstrb_i[2]) irq_en_d = mem_wdata_i[16];
                end
                default: ;
            endcase
        end
        // Sticky sets win over a simultaneous clear.
        if (push_req && full) ovf_d = 1'b1;
        if (load && empty)    udr_d = 1'b1;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            clkdiv_q  <= '0;
            thresh_q  <= '0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            udr_q     <= 1'b0;
            irq_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            div_cnt_q <= '0;
            div_lim_q <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            sd_q      <= 1'b0;
            sr_q      <= '0;
            bit_q     <= 5'd31;
        end else begin
            ready_q  <= accept;
            rdata_q  <= is_read ? rd_val : 32'd0;
            en_q     <= en_d;
            clkdiv_q <= clkdiv_d;
            thresh_q <= thresh_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            udr_q    <= udr_d;
            irq_q    <= irq_en_q & (count_q <= thresh_q);
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            if (!en_q) begin
                // Idle: the divider limit tracks the pending clkdiv so enabling starts at the new rate.
                div_cnt_q <= '0;
                div_lim_q <= clkdiv_d;
                sck_q     <= 1'b0;
                ws_q      <= 1'b0;
                sd_q      <= 1'b0;
                sr_q      <= '0;
                bit_q     <= 5'd31;
            end else if (terminal) begin
                div_cnt_q <= '0;
                div_lim_q <= clkdiv_q;
                sck_q     <= ~sck_q;
                if (fall_ev) begin
                    sd_q  <= sr_q[31];
                    bit_q <= bit_q + 5'd1;
                    if (bit_q == 5'd15)      ws_q <= 1'b1;
                    else if (bit_q == 5'd31) ws_q <= 1'b0;
                    if (load) sr_q <= pop ? fifo_mem[rd_ptr_q] : 32'd0;
                    else      sr_q <= {sr_q[30:0], 1'b0};
                end
            end else begin
                div_cnt_q <= div_cnt_q + 8'd1;
            end
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign i2s_sck_o   = sck_q;
    assign i2s_ws_o    = ws_q;
    assign i2s_sd_o    = sd_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_nmi_i2s_tx.sv
// Bench for nmi_i2s_tx: a frame-level reference (event number -> bit index, word queue)
// checked against the DUT every cycle, plus directed register and serial-stream literals.
module tb_nmi_i2s_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        i2s_sck, i2s_ws, i2s_sd, irq;

    localparam logic [31:0] A_CTRL = 32'h0, A_STAT = 32'h4, A_TX = 32'h8, A_IRQ = 32'hC;

    always #5 clk = ~clk;

    nmi_i2s_tx #(.FIFO_DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_valid_i(mem_valid), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_wstrb_i(mem_wstrb), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
        .i2s_sck_o(i2s_sck), .i2s_ws_o(i2s_ws), .i2s_sd_o(i2s_sd), .irq_o(irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_ready, m_sck, m_ws, m_sd, m_irq, m_en, m_irqen, m_ovf, m_udr;
    logic [31:0] m_rdata, m_cur;
    logic [7:0]  m_clkdiv;
    logic [4:0]  m_thr;
    logic [31:0] mq[$];
    int          m_n, m_last, m_b, m_cnt;

    initial begin : model
        logic        o_en, o_ovf, o_udr, o_irqen, ovf_set, udr_set, ovf_clr, udr_clr;
        logic [7:0]  o_div;
        logic [4:0]  o_thr;
        logic [31:0] rv;
        int          o_size, per, ev, b, k;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ready = 0; m_rdata = 0; m_sck = 0; m_ws = 0; m_sd = 0; m_irq = 0;
                m_en = 0; m_irqen = 0; m_ovf = 0; m_udr = 0; m_clkdiv = 0; m_thr = 0;
                m_cur = 0; m_n = 0; m_last = 0; m_b = 31;
                mq.delete();
            end else begin
                o_en = m_en; o_div = m_clkdiv; o_ovf = m_ovf; o_udr = m_udr;
                o_irqen = m_irqen; o_thr = m_thr; o_size = mq.size();
                ovf_set = 0; udr_set = 0; ovf_clr = 0; udr_clr = 0;
                m_irq = o_irqen && (o_size <= int'(o_thr));
                // serial engine: time since enable determines SCK and event number
                if (!o_en) begin
                    m_n = 0; m_sck = 0; m_ws = 0; m_sd = 0; m_cur = 0; m_last = 0; m_b = 31;
                end else begin
                    m_n++;
                    per = int'(o_div) + 1;
                    m_sck = ((m_n / per) % 2) == 1;
                    if (m_n % (2 * per) == 0) begin
                        ev = m_n / (2 * per);
                        b  = (ev + 30) % 32;
                        k  = ev - 1 - m_last;
                        m_sd = m_cur[31 - k];
                        if (b == 15) m_ws = 1;
                        else if (b == 31) m_ws = 0;
                        if (b == 31) begin
                            m_last = ev;
                            if (mq.size() > 0) m_cur = mq.pop_front();
                            else begin m_cur = 0; udr_set = 1; end
                        end
                        m_b = (b + 1) % 32;
                    end
                end
                // bus
                if (mem_valid && !m_ready) begin
                    m_ready = 1;
                    rv = 0;
                    case (mem_addr[3:2])
                        2'd0: rv = {16'h0, o_div, 7'h0, o_en};
                        2'd1: rv = {19'h0, 5'(o_size), 4'h0, o_udr, o_ovf,
                                    1'(o_size == 0), 1'(o_size == 16)};
                        2'd3: rv = {15'h0, o_irqen, 11'h0, o_thr};
                        default: rv = 0;
                    endcase
                    m_rdata = (mem_wstrb == 0) ? rv : 32'h0;
                    if (mem_wstrb != 0) begin
                        case (mem_addr[3:2])
                            2'd0: begin
                                if (mem_wstrb[0]) m_en = mem_wdata[0];
                                if (mem_wstrb[1]) m_clkdiv = mem_wdata[15:8];
                            end
                            2'd1: if (mem_wstrb[0]) begin
                                ovf_clr = mem_wdata[2]; udr_clr = mem_wdata[3];
                            end
                            2'd2: if (mem_wstrb == 4'hF) begin
                                if (o_size == 16) ovf_set = 1;
                                else mq.push_back(mem_wdata);
                            end
                            default: begin
                                if (mem_wstrb[0]) m_thr = mem_wdata[4:0];
                                if (mem_wstrb[2]) m_irqen = mem_wdata[16];
                            end
                        endcase
                    end
                end else begin
                    m_ready = 0; m_rdata = 0;
                end
                m_ovf = (o_ovf && !ovf_clr) || ovf_set;
                m_udr = (o_udr && !udr_clr) || udr_set;
            end
            m_cnt = mq.size();
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("ready", {31'h0, mem_ready}, {31'h0, m_ready});
            chk("rdata", mem_rdata, m_rdata);
            chk("i2s_sck_ws_sd", {29'h0, i2s_sck, i2s_ws, i2s_sd}, {29'h0, m_sck, m_ws, m_sd});
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    // Serial capture on DUT SCK rising edges, used for the literal stream checks.
    logic        prev_sck = 1'b0;
    logic [63:0] cap = '0, wcap = '0;
    int          rise_cnt = 0;
    initial begin : capture
        forever begin
            @(negedge clk);
            if (i2s_sck && !prev_sck) begin
                rise_cnt++;
                cap  = {cap[62:0], i2s_sd};
                wcap = {wcap[62:0], i2s_ws};
            end
            prev_sck = i2s_sck;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata);
        int t;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
        t = 0;
        @(negedge clk);
        while (!mem_ready && t < 8) begin
            t++;
            @(negedge clk);
        end
        chk("ack_latency", t, 0);
        rdata = mem_rdata;
        mem_valid = 1'b0; mem_wstrb = 4'h0; mem_wdata = '0;
        $display("bus addr=%h wdata=%h strb=%h rdata=%h", addr, wdata, strb, rdata);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        bus(addr, wdata, 4'hF, d);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus(addr, 32'h0, 4'h0, d);
        chk(name, d, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int base, t;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        rd_chk("stat_reset", A_STAT, 32'h0000_0002);

        // 2: one stereo word at clkdiv=0
        wr(A_TX, 32'hA5A5_3C3C);
        base = rise_cnt;
        wr(A_CTRL, 32'h0000_0001);
        t = 0;
        while (rise_cnt < base + 34 && t < 300) begin @(posedge clk); t++; end
        chk("stream_wait", {31'h0, 1'(t < 300)}, 32'h1);
        chk("sd_stream", cap[31:0], 32'hA5A5_3C3C);
        chk("ws_stream", wcap[31:0], 32'h0001_FFFE);
        wr(A_CTRL, 32'h0);
        rd_chk("stat_underrun", A_STAT, 32'h0000_000A);
        wr(A_STAT, 32'h8);
        rd_chk("stat_udr_clr", A_STAT, 32'h0000_0002);

        // 3: overflow with en=0
        for (int i = 0; i < 17; i++) wr(A_TX, 32'h0101_0101 * (i + 1));
        rd_chk("stat_full_ovf", A_STAT, 32'h0000_1005);
        wr(A_STAT, 32'h4);
        rd_chk("stat_ovf_clr", A_STAT, 32'h0000_1001);

        // 5: low-water interrupt while draining
        wr(A_IRQ, 32'h0001_0002);
        rd_chk("irqcfg_read", A_IRQ, 32'h0001_0002);
        repeat (3) @(negedge clk);
        chk("irq_full", {31'h0, irq}, 32'h0);
        wr(A_CTRL, 32'h0000_0001);
        t = 0;
        while (!irq && t < 2000) begin @(negedge clk); t++; end
        chk("irq_wait", {31'h0, 1'(t < 2000)}, 32'h1);
        rd_chk("stat_cnt2", A_STAT, 32'h0000_0200);
        repeat (250) @(negedge clk);
        rd_chk("stat_drained", A_STAT, 32'h0000_000A);

        // 4: enable on empty FIFO at clkdiv=2, then feed one word
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h8);
        wr(A_CTRL, 32'h0000_0201);
        rd_chk("ctrl_read", A_CTRL, 32'h0000_0201);
        repeat (40) @(negedge clk);
        rd_chk("stat_udr_empty", A_STAT, 32'h0000_000A);
        wr(A_STAT, 32'h8);
        wr(A_TX, 32'h1234_8765);
        t = 0;
        while (m_cnt != 0 && t < 400) begin @(negedge clk); t++; end
        chk("load_wait", {31'h0, 1'(t < 400)}, 32'h1);

        // 6: disable mid-frame, then re-enable with a fresh frame
        t = 0;
        while (m_b != 20 && t < 400) begin @(negedge clk); t++; end
        chk("b20_wait", {31'h0, 1'(t < 400)}, 32'h1);
        wr(A_CTRL, 32'h0000_0200);
        @(negedge clk);
        chk("pins_off", {29'h0, i2s_sck, i2s_ws, i2s_sd}, 32'h0);
        wr(A_TX, 32'hFFFF_0001);
        wr(A_TX, 32'h8000_7FFF);
        wr(A_CTRL, 32'h0000_0201);
        repeat (60) @(negedge clk);
        rd_chk("stat_reenable", A_STAT, 32'h0000_0100);
        repeat (300) @(negedge clk);

        // reset while running clears everything
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_chk("stat_after_rst", A_STAT, 32'h0000_0002);
        rd_chk("ctrl_after_rst", A_CTRL, 32'h0000_0000);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
